// File: rtl/race_tracker.sv
// Race-timing controller: start-light countdown, false-start detection,
// distance accumulation with finish clamp, and timeout (DNF) handling.
module race_tracker #(
   parameter int TRACK_LEN   = 40000,
   parameter int LIGHT_TICKS = 100,
   parameter int MAX_TIME    = 6000
) (
   input  logic        clk100Hz,
   input  logic        rst,
   input  logic        start,
   input  logic        throttle,
   input  logic [4:0]  d_position,
   output logic        reset_status,
   output logic [2:0]  lights,
   output logic        racing,
   output logic        finished,
   output logic        false_start,
   output logic        dnf,
   output logic [19:0] position,
   output logic [15:0] race_time
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      COUNTDOWN   = 3'd1,
      RACE        = 3'd2,
      FINISH      = 3'd3,
      FALSE_START = 3'd4
   } state_t;

   localparam logic [19:0] TRACK_END  = 20'(TRACK_LEN);
   localparam logic [15:0] TIME_LIMIT = 16'(MAX_TIME);
   localparam logic [8:0]  LIGHT_1    = 9'(LIGHT_TICKS);
   localparam logic [8:0]  LIGHT_2    = 9'(2 * LIGHT_TICKS);
   localparam logic [8:0]  CNT_LAST   = 9'(3 * LIGHT_TICKS - 1);

   state_t      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [19:0] position_q, position_d;
   logic [15:0] race_time_q, race_time_d;
   logic        dnf_q, dnf_d;
   logic        reset_status_q, reset_status_d;
   logic [2:0]  lights_q, lights_d;
   logic        racing_q, racing_d;
   logic        finished_q, finished_d;
   logic        false_start_q, false_start_d;
   logic [19:0] sum;
   logic [15:0] time_inc;

   always_ff @(posedge clk100Hz) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      position_q     <= position_d;
      race_time_q    <= race_time_d;
      dnf_q          <= dnf_d;
      reset_status_q <= reset_status_d;
      lights_q       <= lights_d;
      racing_q       <= racing_d;
      finished_q     <= finished_d;
      false_start_q  <= false_start_d;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      position_d  = position_q;
      race_time_d = race_time_q;
      dnf_d       = dnf_q;
      // Position never exceeds TRACK_END, so this 20-bit sum cannot wrap.
      sum         = position_q + {15'd0, d_position};
      time_inc    = race_time_q + 16'd1;

      case (state_q)
         IDLE: begin
            cnt_d       = '0;
            position_d  = '0;
            race_time_d = '0;
            dnf_d       = 1'b0;
            if (start) state_d = COUNTDOWN;
         end
         COUNTDOWN: begin
            if (throttle)             state_d = FALSE_START;
            else if (cnt_q == CNT_LAST) state_d = RACE;
            else                      cnt_d = cnt_q + 9'd1;
         end
         RACE: begin
            race_time_d = time_inc;
            if (sum >= TRACK_END) begin
               position_d = TRACK_END;
               dnf_d      = 1'b0;
               state_d    = FINISH;
            end else begin
               position_d = sum;
               if (time_inc == TIME_LIMIT) begin
                  dnf_d   = 1'b1;
                  state_d = FINISH;
               end
            end
         end
         FINISH, FALSE_START: begin
            if (start) begin
               cnt_d       = '0;
               position_d  = '0;
               race_time_d = '0;
               dnf_d       = 1'b0;
               state_d     = COUNTDOWN;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         state_d     = IDLE;
         cnt_d       = '0;
         position_d  = '0;
         race_time_d = '0;
         dnf_d       = 1'b0;
      end

      // Status outputs are decoded from the next state so they register alongside it.
      reset_status_d = (state_d != RACE);
      racing_d       = (state_d == RACE);
      finished_d     = (state_d == FINISH);
      false_start_d  = (state_d == FALSE_START);
      lights_d       = 3'b000;
      if (state_d == COUNTDOWN) begin
         if (cnt_d < LIGHT_1)      lights_d = 3'b001;
         else if (cnt_d < LIGHT_2) lights_d = 3'b011;
         else                      lights_d = 3'b111;
      end
   end

   assign reset_status = reset_status_q;
   assign lights       = lights_q;
   assign racing       = racing_q;
   assign finished     = finished_q;
   assign false_start  = false_start_q;
   assign dnf          = dnf_q;
   assign position     = position_q;
   assign race_time    = race_time_q;

endmodule

// File: tb/tb_race_tracker.sv
// Directed bench for race_tracker: countdown timing, false start, exact and
// clamped finish, timeout DNF, and mid-race reset.
module tb_race_tracker;

   logic        clk100Hz = 1'b0;
   logic        rst;
   logic        start;
   logic        throttle;
   logic [4:0]  d_position;
   logic        reset_status;
   logic [2:0]  lights;
   logic        racing;
   logic        finished;
   logic        false_start;
   logic        dnf;
   logic [19:0] position;
   logic [15:0] race_time;

   int checks   = 0;
   int failures = 0;

   race_tracker #(
      .TRACK_LEN  (1000),
      .LIGHT_TICKS(100),
      .MAX_TIME   (6000)
   ) dut (
      .clk100Hz    (clk100Hz),
      .rst         (rst),
      .start       (start),
      .throttle    (throttle),
      .d_position  (d_position),
      .reset_status(reset_status),
      .lights      (lights),
      .racing      (racing),
      .finished    (finished),
      .false_start (false_start),
      .dnf         (dnf),
      .position    (position),
      .race_time   (race_time)
   );

   always #5 clk100Hz = ~clk100Hz;

   // Advance one rising edge; return at the falling edge for sampling/driving.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk100Hz);
         @(negedge clk100Hz);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Packs {reset_status, lights, racing, finished, false_start, dnf} for compact checks.
   function automatic logic [31:0] flags();
      return {24'd0, reset_status, lights, racing, finished, false_start, dnf};
   endfunction

   localparam logic [31:0] F_IDLE   = 32'b1_000_0000;
   localparam logic [31:0] F_L1     = 32'b1_001_0000;
   localparam logic [31:0] F_L2     = 32'b1_011_0000;
   localparam logic [31:0] F_L3     = 32'b1_111_0000;
   localparam logic [31:0] F_RACE   = 32'b0_000_1000;
   localparam logic [31:0] F_FIN    = 32'b1_000_0100;
   localparam logic [31:0] F_DNF    = 32'b1_000_0101;
   localparam logic [31:0] F_FALSE  = 32'b1_000_0010;

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; throttle = 1'b0; d_position = 5'd0;
      @(negedge clk100Hz);
      tick(3);
      check("reset_flags", flags(), F_IDLE);
      check("reset_pos", 32'(position), 32'd0);
      check("reset_time", 32'(race_time), 32'd0);

      // Countdown timing; d_position is nonzero but must be ignored until RACE.
      rst = 1'b0;
      d_position = 5'd20;
      tick(2);
      check("idle_hold", flags(), F_IDLE);
      check("idle_pos", 32'(position), 32'd0);
      pulse_start();
      check("cd_c1", flags(), F_L1);
      tick(99);
      check("cd_c100", flags(), F_L1);
      tick();
      check("cd_c101", flags(), F_L2);
      tick(99);
      check("cd_c200", flags(), F_L2);
      tick();
      check("cd_c201", flags(), F_L3);
      tick(99);
      check("cd_c300", flags(), F_L3);
      check("cd_pos", 32'(position), 32'd0);
      tick();
      check("cd_c301_race", flags(), F_RACE);
      check("race_entry_pos", 32'(position), 32'd0);

      // Exact finish with d=20; start and throttle are ignored while racing.
      start = 1'b1; throttle = 1'b1;
      tick(10);
      start = 1'b0; throttle = 1'b0;
      check("race_ignore", flags(), F_RACE);
      check("race_pos10", 32'(position), 32'd200);
      tick(39);
      check("race_pos49", 32'(position), 32'd980);
      check("race_time49", 32'(race_time), 32'd49);
      check("race_flags49", flags(), F_RACE);
      tick();
      check("fin_flags", flags(), F_FIN);
      check("fin_pos", 32'(position), 32'd1000);
      check("fin_time", 32'(race_time), 32'd50);
      tick(5);
      check("fin_frozen_pos", 32'(position), 32'd1000);
      check("fin_frozen_time", 32'(race_time), 32'd50);
      check("fin_frozen_flags", flags(), F_FIN);

      // Restart from FINISH, then false start at cnt=50.
      pulse_start();
      check("restart_flags", flags(), F_L1);
      check("restart_pos", 32'(position), 32'd0);
      check("restart_time", 32'(race_time), 32'd0);
      tick(50);
      throttle = 1'b1;
      tick();
      throttle = 1'b0;
      check("fs_flags", flags(), F_FALSE);
      check("fs_pos", 32'(position), 32'd0);
      tick(3);
      check("fs_hold", flags(), F_FALSE);
      pulse_start();
      check("fs_restart", flags(), F_L1);

      // Overshoot clamp with d=31 (this countdown already started).
      d_position = 5'd31;
      tick(300);
      check("os_race", flags(), F_RACE);
      tick(32);
      check("os_pos32", 32'(position), 32'd992);
      check("os_flags32", flags(), F_RACE);
      tick();
      check("os_fin_flags", flags(), F_FIN);
      check("os_pos", 32'(position), 32'd1000);
      check("os_time", 32'(race_time), 32'd33);

      // Mid-race reset held for 3 cycles.
      pulse_start();
      d_position = 5'd5;
      tick(300);
      tick(4);
      check("mr_pos", 32'(position), 32'd20);
      rst = 1'b1;
      start = 1'b1;
      throttle = 1'b1;
      tick();
      check("mr_rst1_flags", flags(), F_IDLE);
      check("mr_rst1_pos", 32'(position), 32'd0);
      tick(2);
      start = 1'b0; throttle = 1'b0;
      check("mr_rst3_flags", flags(), F_IDLE);
      check("mr_rst3_time", 32'(race_time), 32'd0);
      rst = 1'b0;

      // Timeout: start sampled on the first cycle after reset release.
      d_position = 5'd0;
      pulse_start();
      check("to_cd", flags(), F_L1);
      tick(300);
      check("to_race", flags(), F_RACE);
      tick(5999);
      check("to_flags5999", flags(), F_RACE);
      check("to_time5999", 32'(race_time), 32'd5999);
      tick();
      check("to_flags", flags(), F_DNF);
      check("to_time", 32'(race_time), 32'd6000);
      check("to_pos", 32'(position), 32'd0);
      pulse_start();
      check("to_restart", flags(), F_L1);
      check("to_restart_time", 32'(race_time), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/race_tracker.md
RACE_TRACKER -- requirements
Module: race_tracker

Interface
REQ-001 Parameter TRACK_LEN, default 40000, meaning race distance in position units; legal range 1 .. 2^20-32.
REQ-002 Parameter LIGHT_TICKS, default 100, meaning clock cycles per countdown light (1 s at 100 Hz).
REQ-003 Parameter MAX_TIME, default 6000, meaning race time in cycles after which the run is declared DNF.
REQ-004 clk100Hz  input  1  race clock (100 Hz); all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  start/restart request, sampled each cycle.
REQ-007 throttle  input  1  driver throttle pressed (level).
REQ-008 d_position  input  5  per-cycle distance increment from the velocity stage.
REQ-009 reset_status  output  1  registered; holds the velocity stage's d_position at 0 when high.
REQ-010 lights  output  3  countdown lamps, thermometer coded.
REQ-011 racing  output  1  high in RACE state.
REQ-012 finished  output  1  high in FINISH state.
REQ-013 false_start  output  1  high in FALSE_START state.
REQ-014 dnf  output  1  high in FINISH when entered by timeout.
REQ-015 position  output  20  accumulated distance, unsigned.
REQ-016 race_time  output  16  race cycles elapsed (centiseconds), unsigned.

Function
REQ-017 FSM states IDLE, COUNTDOWN, RACE, FINISH, FALSE_START; all outputs registered.
REQ-018 IDLE: start=1 -> COUNTDOWN next cycle; position, race_time, countdown counter cleared to 0.
REQ-019 COUNTDOWN: 9-bit counter cnt = 0 on entry, +1 per cycle; lights=001 for cnt 0..LIGHT_TICKS-1, 011 for LIGHT_TICKS..2*LIGHT_TICKS-1, 111 for 2*LIGHT_TICKS..3*LIGHT_TICKS-1.
REQ-020 COUNTDOWN: at cnt=3*LIGHT_TICKS-1 with throttle=0 -> RACE next cycle.
REQ-021 COUNTDOWN: throttle=1 on any cycle -> FALSE_START next cycle; takes priority over REQ-020 transition.
REQ-022 reset_status=1 in IDLE, COUNTDOWN, FINISH, FALSE_START; 0 only in RACE.
REQ-023 RACE: lights=000; each cycle position <= position + d_position, race_time <= race_time + 1.
REQ-024 RACE: if position + d_position >= TRACK_LEN -> position <= TRACK_LEN (clamped), race_time incremented for that cycle, FINISH next cycle, dnf=0.
REQ-025 RACE: else if race_time + 1 = MAX_TIME -> FINISH next cycle with dnf=1, position accumulated normally; distance check has priority on same cycle.
REQ-026 FINISH/FALSE_START: position, race_time frozen; lights=000; start=1 -> COUNTDOWN with counters cleared, finished/false_start/dnf cleared.
REQ-027 start ignored in COUNTDOWN and RACE; throttle ignored outside COUNTDOWN.
REQ-028 Arithmetic: 20-bit sum with zero-extended d_position; compare before clamp; no wrap possible within legal TRACK_LEN.
REQ-029 d_position ignored (not accumulated) in all states except RACE.

Reset
REQ-030 rst=1 overrides all inputs: state=IDLE, reset_status=1, lights=000, racing=finished=false_start=dnf=0, position=0, race_time=0, cnt=0; applies mid-race.
REQ-031 First cycle after rst release behaves as IDLE (start sampled that cycle).

Verification
REQ-032 Reset: hold rst 3 cycles during RACE -> all outputs at REQ-030 values on the next edge.
REQ-033 Countdown (LIGHT_TICKS=100): start pulse at cycle 0 -> lights 001 at cycle 1, 011 at 101, 111 at 201, racing=1 and reset_status=0 at 301.
REQ-034 False start: throttle=1 at countdown cnt=50 -> false_start=1 next cycle, lights=000, position=0; later start pulse -> COUNTDOWN, false_start=0.
REQ-035 Exact finish: TRACK_LEN=1000, d_position=20 constant in RACE -> finished=1 after 50 race cycles, position=1000, race_time=50, dnf=0.
REQ-036 Overshoot clamp: TRACK_LEN=1000, d_position=31 -> at race cycle 33 sum 1023 clamps, position=1000, race_time=33.
REQ-037 Timeout: MAX_TIME=6000, d_position=0 -> finished=1, dnf=1, race_time=6000, position=0; start pulse restarts countdown.
